// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read channel among several
// instruction fetchers, with a single transaction outstanding at a time.
module program_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  localparam int GRANT_BITS   = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic [GRANT_BITS-1:0]              grant_id,
  output logic                               busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    READ_WAITING = 2'd1,
    RELAYING     = 2'd2
  } state_t;

  state_t                             state_r, state_s;
  logic [GRANT_BITS-1:0]              rr_ptr_r, rr_ptr_s;
  logic [GRANT_BITS-1:0]              winner_s, grant_s;
  logic                               found_s;
  logic                               mem_valid_s, busy_s;
  logic [ADDR_BITS-1:0]               mem_addr_s;
  logic [NUM_CONSUMERS-1:0]           ready_s;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_s;

  // Modular add for consumer indices; both operands are always below NUM_CONSUMERS.
  function automatic logic [GRANT_BITS-1:0] wrap_add(input logic [GRANT_BITS-1:0] base,
                                                     input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_CONSUMERS) begin
      sum = sum - NUM_CONSUMERS;
    end else begin
      sum = sum;
    end
    return GRANT_BITS'(sum);
  endfunction

  // Round-robin search: first requesting consumer at or after rr_ptr.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (!found_s && consumer_read_valid[wrap_add(rr_ptr_r, i)]) begin
        winner_s = wrap_add(rr_ptr_r, i);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and next-output values; every register holds by default.
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    grant_s     = grant_id;
    mem_valid_s = mem_read_valid;
    mem_addr_s  = mem_read_address;
    ready_s     = consumer_read_ready;
    data_s      = consumer_read_data;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s     = READ_WAITING;
          mem_valid_s = 1'b1;
          mem_addr_s  = consumer_read_address[int'(winner_s)*ADDR_BITS +: ADDR_BITS];
          grant_s     = winner_s;
        end else begin
          state_s     = IDLE;
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          state_s           = RELAYING;
          mem_valid_s       = 1'b0;
          ready_s[grant_id] = 1'b1;
          data_s[int'(grant_id)*DATA_BITS +: DATA_BITS] = mem_read_data;
          rr_ptr_s          = wrap_add(grant_id, 32'sd1);
        end else begin
          state_s           = READ_WAITING;
        end
      end
      RELAYING: begin
        // Leaving only once the fetcher withdraws keeps a stale valid from re-granting.
        if (!consumer_read_valid[grant_id]) begin
          state_s           = IDLE;
          ready_s[grant_id] = 1'b0;
        end else begin
          state_s           = RELAYING;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_s;
      rr_ptr_r <= rr_ptr_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
      grant_id            <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
      busy                <= 1'b0;
    end else begin
      mem_read_valid      <= mem_valid_s;
      mem_read_address    <= mem_addr_s;
      grant_id            <= grant_s;
      consumer_read_ready <= ready_s;
      consumer_read_data  <= data_s;
      busy                <= busy_s;
    end
  end

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Testbench for program_mem_arbiter: behavioural memory and fetcher models,
// an in-order response scoreboard, a vector table and corner-case sequences.
module tb_program_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    consumer_read_valid;
  logic [N*AW-1:0] consumer_read_address;
  logic [N-1:0]    consumer_read_ready;
  logic [N*DW-1:0] consumer_read_data;
  logic            mem_read_valid;
  logic [AW-1:0]   mem_read_address;
  logic            mem_read_ready;
  logic [DW-1:0]   mem_read_data;
  logic [1:0]      grant_id;
  logic            busy;

  typedef struct { int id; logic [AW-1:0] addr; logic [DW-1:0] data; } exp_t;
  typedef struct { bit rst; logic [3:0] req; logic [31:0] addrs; int lat; int n; logic [7:0] order; } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int checks = 0;
  int failures = 0;
  int mem_lat, mem_cnt, busy_run;
  bit mem_en, tie, ovr_en, mem_v_prev, busy_prev, idle_seen;
  logic [DW-1:0] ovr_val;
  int rdy_cnt[N];
  logic [DW-1:0] exp_data[N];

  program_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  function automatic logic [N*DW-1:0] exp_bus();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = exp_data[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then update memory and fetcher models.
  task automatic tick();
    exp_t e;
    logic [N-1:0] oh;
    @(negedge clk);
    if (tie) begin
      mem_read_ready = 1'b1;
      mem_read_data  = ovr_en ? ovr_val : mem_fn(mem_read_address);
    end else if (mem_en) begin
      if (mem_read_ready) begin
        mem_read_ready = 1'b0;
        mem_cnt = 0;
      end else if (mem_read_valid) begin
        if (mem_cnt >= mem_lat) begin
          mem_read_ready = 1'b1;
          mem_read_data  = ovr_en ? ovr_val : mem_fn(mem_read_address);
        end else begin
          mem_cnt++;
        end
      end
    end
    if (mem_read_valid && !mem_v_prev) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_request actual=%h expected=none", mem_read_address);
      end else begin
        chk("mem_addr", 64'(mem_read_address), 64'(sb[0].addr));
        chk("grant_id", 64'(grant_id), 64'(sb[0].id));
      end
      if (tie) chk("idle_gap", 64'(idle_seen), 64'd1);
      idle_seen = 1'b0;
    end
    mem_v_prev = mem_read_valid;
    if (!busy) idle_seen = 1'b1;
    if (busy) busy_run++;
    else begin
      if (busy_prev && tie) chk("busy_len", 64'(busy_run), 64'd3);
      busy_run = 0;
    end
    busy_prev = busy;
    for (int i = 0; i < N; i++) begin
      if (consumer_read_ready[i]) begin
        rdy_cnt[i]++;
        if (rdy_cnt[i] == 1) begin
          oh = 4'b0001 << i;
          chk("ready_onehot", 64'(consumer_read_ready), 64'(oh));
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_response actual=%0d expected=none", i);
          end else begin
            e = sb.pop_front();
            chk("resp_id", 64'(i), 64'(e.id));
            chk("resp_data", 64'(consumer_read_data[i*DW +: DW]), 64'(e.data));
            exp_data[e.id] = e.data;
          end
        end else if (rdy_cnt[i] == 2) begin
          consumer_read_valid[i] = 1'b0;
        end
      end else begin
        if (rdy_cnt[i] != 0) chk("ready_len", 64'(rdy_cnt[i]), 64'd2);
        rdy_cnt[i] = 0;
      end
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (sb.size() == 0 && consumer_read_valid == '0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout actual=pending%0d expected=pending0", name, sb.size());
      sb.delete();
      consumer_read_valid = '0;
    end
    tick();
    tick();
    chk({name, "_slices"}, 64'(consumer_read_data), 64'(exp_bus()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    consumer_read_valid = '0;
    mem_read_ready = 1'b0;
    mem_cnt = 0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin exp_data[i] = '0; rdy_cnt[i] = 0; end
  endtask

  initial begin
    int id;
    logic [AW-1:0] a;
    vecs[0] = '{1'b1, 4'b1011, 32'h30201000, 1, 3, 8'b00_11_01_00};
    vecs[1] = '{1'b0, 4'b1001, 32'h3C00000C, 2, 2, 8'b00_00_11_00};
    vecs[2] = '{1'b0, 4'b1111, 32'h77665544, 0, 4, 8'b11_10_01_00};
    vecs[3] = '{1'b0, 4'b0110, 32'hAABBCCDD, 2, 2, 8'b00_00_10_01};
    vecs[4] = '{1'b0, 4'b0101, 32'h01020304, 1, 2, 8'b00_00_10_00};
    vecs[5] = '{1'b0, 4'b1111, 32'hF0E0D0C0, 4, 4, 8'b10_01_00_11};

    reset = 1'b1; consumer_read_valid = '0; consumer_read_address = '0;
    mem_read_ready = 1'b0; mem_read_data = '0;
    mem_en = 1'b1; tie = 1'b0; ovr_en = 1'b0; ovr_val = '0; mem_lat = 0; mem_cnt = 0;
    busy_run = 0; mem_v_prev = 1'b0; busy_prev = 1'b0; idle_seen = 1'b1;
    for (int i = 0; i < N; i++) begin exp_data[i] = '0; rdy_cnt[i] = 0; end
    tick();
    tick();
    chk("rst_mem_valid", 64'(mem_read_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_read_address), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(consumer_read_ready), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_data", 64'(consumer_read_data), 64'd0);
    reset = 1'b0;

    // Single request from consumer 2.
    mem_lat = 3; ovr_en = 1'b1; ovr_val = 16'hBEEF;
    consumer_read_address[2*AW +: AW] = 8'h1A;
    sb.push_back('{2, 8'h1A, 16'hBEEF});
    consumer_read_valid[2] = 1'b1;
    tick();
    chk("latency_valid", 64'(mem_read_valid), 64'd1);
    chk("latency_busy", 64'(busy), 64'd1);
    wait_done("single", 100);
    ovr_en = 1'b0;

    for (int r = 0; r < 6; r++) begin
      if (vecs[r].rst) do_reset();
      consumer_read_address = vecs[r].addrs;
      mem_lat = vecs[r].lat;
      for (int k = 0; k < vecs[r].n; k++) begin
        id = int'(vecs[r].order[k*2 +: 2]);
        a  = vecs[r].addrs[id*AW +: AW];
        sb.push_back('{id, a, mem_fn(a)});
      end
      consumer_read_valid = vecs[r].req;
      wait_done("vec", 400);
    end

    // Zero-latency memory: ready tied high.
    tie = 1'b1; mem_read_ready = 1'b1; idle_seen = 1'b1;
    consumer_read_address = 32'h00230021;
    sb.push_back('{0, 8'h21, mem_fn(8'h21)});
    sb.push_back('{2, 8'h23, mem_fn(8'h23)});
    consumer_read_valid = 4'b0101;
    wait_done("zero_lat", 100);
    tie = 1'b0; mem_read_ready = 1'b0;
    tick();

    // Memory response while idle must be ignored.
    mem_en = 1'b0; mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
    tick();
    chk("ign_ready0", 64'(consumer_read_ready), 64'd0);
    chk("ign_busy", 64'(busy), 64'd0);
    tick();
    chk("ign_ready1", 64'(consumer_read_ready), 64'd0);
    chk("ign_slices", 64'(consumer_read_data), 64'(exp_bus()));
    mem_read_ready = 1'b0;

    // Reset while waiting on memory, then a late response.
    consumer_read_address[1*AW +: AW] = 8'h55;
    sb.push_back('{1, 8'h55, mem_fn(8'h55)});
    consumer_read_valid[1] = 1'b1;
    for (int c = 0; c < 20 && !mem_read_valid; c++) tick();
    chk("mid_req_seen", 64'(mem_read_valid), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_mem_valid", 64'(mem_read_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ready", 64'(consumer_read_ready), 64'd0);
    chk("mid_grant", 64'(grant_id), 64'd0);
    chk("mid_data", 64'(consumer_read_data), 64'd0);
    reset = 1'b0;
    consumer_read_valid = '0;
    sb.delete();
    for (int i = 0; i < N; i++) exp_data[i] = '0;
    mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
    tick();
    tick();
    chk("late_ready", 64'(consumer_read_ready), 64'd0);
    chk("late_busy", 64'(busy), 64'd0);
    chk("late_data", 64'(consumer_read_data), 64'd0);
    mem_read_ready = 1'b0; mem_en = 1'b1; mem_cnt = 0; mem_lat = 1;
    consumer_read_address = 32'h63006100;
    sb.push_back('{1, 8'h61, mem_fn(8'h61)});
    sb.push_back('{3, 8'h63, mem_fn(8'h63)});
    consumer_read_valid = 4'b1010;
    wait_done("post_reset", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
